// File: rtl/integral_buffer_pkg.sv
// Shared helpers for the binary-image integral line buffer: width math and
// the bit offset of one packed integral entry.
package integral_buffer_pkg;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Bit offset of I(r,c) inside the packed integral, row-major, I(0,0) in LSBs.
  function automatic int idx(input int r, input int c, input int n, input int w);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/integral_window_calc.sv
// Combinational integral of an n x n binary window: a prefix sum along each
// row, then a prefix sum of those row sums down each column.
module integral_window_calc
  import integral_buffer_pkg::*;
#(
  parameter int WindowSize = 4,
  parameter int wdI        = 5
) (
  input  logic [WindowSize*WindowSize-1:0]     win,
  output logic [wdI*WindowSize*WindowSize-1:0] integ
);

  localparam int n = WindowSize;

  for (genvar gi = 0; gi < n; gi++) begin : g_r
    for (genvar gj = 0; gj < n; gj++) begin : g_c
      logic [wdI-1:0] rsum;
      logic [wdI-1:0] csum;

      if (gj == 0) begin : g_rfirst
        assign rsum = wdI'(win[gi*n]);
      end else begin : g_rnext
        assign rsum = g_r[gi].g_c[gj-1].rsum + wdI'(win[gi*n+gj]);
      end

      if (gi == 0) begin : g_cfirst
        assign csum = rsum;
      end else begin : g_cnext
        assign csum = g_r[gi-1].g_c[gj].csum + rsum;
      end

      assign integ[idx(gi, gj, n, wdI) +: wdI] = csum;
    end
  end

endmodule

// File: rtl/integral_buffer.sv
// Circular line buffer of the last WindowSize binary rows; one edge after each
// pixel write it registers the integral of the window ending at that pixel.
module integral_buffer
  import integral_buffer_pkg::*;
#(
  parameter int ImageWidth  = 7,
  parameter int ImageHeight = 5,
  parameter int WindowSize  = 4,
  localparam int wd  = clog2(ImageWidth + 1),
  localparam int wdI = clog2(WindowSize * WindowSize + 1)
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  WriteEnable,
  input  logic [wd-1:0]                         Addr,
  input  logic                                  Data,
  output logic                                  BufferReady,
  output logic [wdI*WindowSize*WindowSize-1:0]  IntegralPacked
);

  localparam int n  = WindowSize;
  localparam int sw = (clog2(n) < 1) ? 1 : clog2(n);
  localparam int rw = clog2(ImageHeight + 1);
  localparam int pw = wdI * n * n;

  logic [ImageWidth-1:0] lines_reg [n];
  logic [sw-1:0]         slot_reg;
  logic [rw-1:0]         row_reg;
  logic [wd-1:0]         col_reg;
  logic [sw-1:0]         pend_slot_reg;
  logic                  pend_reg;
  logic                  pend_valid_reg;
  logic                  ready_reg;
  logic [pw-1:0]         integ_reg;

  logic                  wr_ok;
  logic                  last_col;
  logic                  win_ok;
  logic [sw-1:0]         slot_next;
  logic [rw-1:0]         row_next;
  logic [wd-1:0]         shift_amt;
  logic [n*n-1:0]        win;
  logic [pw-1:0]         integ_calc;

  assign wr_ok    = WriteEnable && (Addr < wd'(ImageWidth));
  assign last_col = (Addr == wd'(ImageWidth - 1));
  assign win_ok   = (row_reg >= rw'(n - 1)) && (Addr >= wd'(n - 1));

  always_comb begin
    slot_next = slot_reg;
    row_next  = row_reg;
    if (last_col) begin
      slot_next = (slot_reg == sw'(n - 1)) ? '0 : slot_reg + sw'(1);
      row_next  = (row_reg == rw'(ImageHeight - 1)) ? '0 : row_reg + rw'(1);
    end
  end

  // Line storage and write-side counters.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < n; i++) lines_reg[i] <= '0;
      slot_reg       <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      pend_slot_reg  <= '0;
      pend_reg       <= 1'b0;
      pend_valid_reg <= 1'b0;
    end else begin
      pend_reg <= 1'b0;
      if (wr_ok) begin
        lines_reg[slot_reg][Addr] <= Data;
        col_reg        <= Addr;
        pend_slot_reg  <= slot_reg;
        pend_reg       <= 1'b1;
        pend_valid_reg <= win_ok;
        slot_reg       <= slot_next;
        row_reg        <= row_next;
      end
    end
  end

  // Window extraction: the slot after the written one holds the oldest row.
  assign shift_amt = col_reg - wd'(n - 1);

  for (genvar gi = 0; gi < n; gi++) begin : g_win
    logic [sw:0]           slot_sum;
    logic [sw:0]           slot_wrap;
    logic [sw-1:0]         slot_sel;
    logic [ImageWidth-1:0] shifted;

    assign slot_sum  = {1'b0, pend_slot_reg} + (sw+1)'(gi + 1);
    assign slot_wrap = slot_sum - (sw+1)'(n);
    assign slot_sel  = (slot_sum >= (sw+1)'(n)) ? slot_wrap[sw-1:0] : slot_sum[sw-1:0];
    assign shifted   = lines_reg[slot_sel] >> shift_amt;
    assign win[gi*n +: n] = shifted[n-1:0];
  end

  integral_window_calc #(
    .WindowSize (n),
    .wdI        (wdI)
  ) u_calc (
    .win   (win),
    .integ (integ_calc)
  );

  // Result stage: an invalid write drops ready but keeps the last integral.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ready_reg <= 1'b0;
      integ_reg <= '0;
    end else if (pend_reg) begin
      ready_reg <= pend_valid_reg;
      if (pend_valid_reg) integ_reg <= integ_calc;
    end
  end

  assign BufferReady    = ready_reg;
  assign IntegralPacked = integ_reg;

endmodule

// File: tb/tb_integral_buffer.sv
// Directed bench for integral_buffer (7x5 image, 4x4 window) with
// hand-computed expected integrals.
module tb_integral_buffer;

  localparam int N  = 4;
  localparam int WI = 5;
  localparam int PW = WI * N * N;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          WriteEnable = 1'b0;
  logic [2:0]    Addr = '0;
  logic          Data = 1'b0;
  logic          BufferReady;
  logic [PW-1:0] IntegralPacked;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] ones_exp;
  logic [PW-1:0] chk_exp;
  int            chk_tab [16] = '{0, 1, 1, 2,  1, 2, 3, 4,  1, 3, 4, 6,  2, 4, 6, 8};

  integral_buffer dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .WriteEnable    (WriteEnable),
    .Addr           (Addr),
    .Data           (Data),
    .BufferReady    (BufferReady),
    .IntegralPacked (IntegralPacked)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [PW-1:0] entry(input logic [PW-1:0] v, input int r, input int c);
    return PW'(v[(r*N+c)*WI +: WI]);
  endfunction

  // One write pulse then three idle cycles; outputs must not move before the
  // second edge and must match exp_rdy after it.
  task automatic wr(input int r, input int c, input logic d, input logic exp_rdy);
    logic          prev_rdy;
    logic [PW-1:0] prev_pk;
    @(negedge Clock);
    prev_rdy    = BufferReady;
    prev_pk     = IntegralPacked;
    WriteEnable = 1'b1;
    Addr        = 3'(c);
    Data        = d;
    @(negedge Clock);
    WriteEnable = 1'b0;
    check($sformatf("lat_rdy r%0d c%0d", r, c), PW'(BufferReady), PW'(prev_rdy));
    check($sformatf("lat_pk r%0d c%0d", r, c), IntegralPacked, prev_pk);
    repeat (2) @(negedge Clock);
    check($sformatf("rdy r%0d c%0d", r, c), PW'(BufferReady), PW'(exp_rdy));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ones_exp[(r*N+c)*WI +: WI] = WI'((r + 1) * (c + 1));
        chk_exp[(r*N+c)*WI +: WI]  = WI'(chk_tab[r*N+c]);
      end

    // Reset and idle
    repeat (3) @(negedge Clock);
    check("reset_rdy", PW'(BufferReady), PW'(0));
    check("reset_pk", IntegralPacked, '0);
    Reset = 1'b1;
    repeat (5) @(negedge Clock);
    check("idle_rdy", PW'(BufferReady), PW'(0));
    check("idle_pk", IntegralPacked, '0);

    // Frame 1: all ones
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 7; c++) begin
        wr(r, c, 1'b1, (r >= 3) && (c >= 3));
        if (r == 3 && c == 3) begin
          check("ones_pk", IntegralPacked, ones_exp);
          check("ones_I33", entry(IntegralPacked, 3, 3), PW'(16));
          check("ones_I00", entry(IntegralPacked, 0, 0), PW'(1));
        end
        if (r == 4 && c == 0) check("hold_pk", IntegralPacked, ones_exp);
        if (r == 4 && c == 3) check("r4c3_I33", entry(IntegralPacked, 3, 3), PW'(16));
      end

    // Frame 2: checkerboard, stop at row 3 column 3
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 7; c++) begin
        if (!(r == 3 && c > 3)) wr(r, c, 1'((r + c) & 1), (r >= 3) && (c >= 3));
      end
    check("chk_pk", IntegralPacked, chk_exp);
    check("chk_I33", entry(IntegralPacked, 3, 3), PW'(8));
    check("chk_I00", entry(IntegralPacked, 0, 0), PW'(0));
    check("chk_I11", entry(IntegralPacked, 1, 1), PW'(2));

    // Out-of-range address is ignored
    @(negedge Clock);
    WriteEnable = 1'b1;
    Addr        = 3'd7;
    Data        = 1'b1;
    @(negedge Clock);
    WriteEnable = 1'b0;
    repeat (3) @(negedge Clock);
    check("addr7_rdy", PW'(BufferReady), PW'(1));
    check("addr7_pk", IntegralPacked, chk_exp);

    // Mid-row asynchronous reset
    @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("midrst_rdy", PW'(BufferReady), PW'(0));
    check("midrst_pk", IntegralPacked, '0);
    @(negedge Clock);
    Reset = 1'b1;

    // Refill four rows of ones; the frame restarts at row 0
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 7; c++) begin
        if (!(r == 3 && c > 3)) wr(r, c, 1'b1, (r >= 3) && (c >= 3));
      end
    check("refill_pk", IntegralPacked, ones_exp);
    check("refill_I33", entry(IntegralPacked, 3, 3), PW'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/integral_buffer.md
# integral_buffer

Line buffer for a binary (1-bit-per-pixel) image stream. It stores the most recent `WindowSize` image rows and, after each pixel write, produces the integral image of the `WindowSize × WindowSize` window ending at the written pixel. The packed integral values feed the downstream window-based feature/classifier stage.

## Interface

Parameters:
- `ImageWidth`, 7: pixels per row (columns).
- `ImageHeight`, 5: rows per frame.
- `WindowSize`, 4: window edge n; the window is n×n.
- Derived `wd` = clog2(ImageWidth+1): address width.
- Derived `wdI` = clog2(n·n+1): width of one integral entry.

Ports (one clock; reset is asynchronous and active-low):
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `WriteEnable`  in  1  write strobe; one pixel is written per cycle while high.
- `Addr`  in  wd  column of the pixel being written.
- `Data`  in  1  pixel value.
- `BufferReady`  out  1  `IntegralPacked` holds a valid full-window integral.
- `IntegralPacked`  out  wdI·n·n  n×n integral entries.

## Operation

- Storage: n row slots × ImageWidth bits, used as a circular buffer. There is a current slot pointer and a row counter `row` (0..ImageHeight−1).
- Write (WriteEnable=1, Addr<ImageWidth): store `Data` at [current slot][Addr] and latch `col`=Addr.
- Writes with Addr ≥ ImageWidth are ignored. They change neither state nor outputs.
- Row advance: a write with Addr=ImageWidth−1 advances the slot pointer (mod n) and increments `row`.
- Frame wrap: a write with Addr=ImageWidth−1 while row=ImageHeight−1 sets `row` to 0. Buffer contents are kept, but the window is not valid again until n new rows exist.
- Columns within a row are written in ascending order; rows are written consecutively.
- Window after a write at (`row`, `col`):
  - Rows `row`−n+1..`row`, where window row r=0 is the oldest.
  - Columns `col`−n+1..`col`, where window column c=0 is the leftmost.
- Valid condition: `row` ≥ n−1 and `col` ≥ n−1, evaluated against the row/col of the write itself, before any row advance.
- Integral entry: I(r,c) = sum of window pixels at rows 0..r and columns 0..c. Range is 0..n·n, unsigned, wdI bits, no overflow possible.
- Packing: I(r,c) occupies bits [(r·n+c)·wdI +: wdI]. I(0,0) is in the LSBs.
- Output update:
  - Valid write: `IntegralPacked` is loaded and `BufferReady`=1.
  - Invalid write: `BufferReady`=0 and `IntegralPacked` holds its previous value.
  - No write: both outputs hold.

## Timing

- Reset (Reset=0, asynchronous): clears all pixel storage, slot pointer, `row`, `col` and the pending flag. `BufferReady`=0, `IntegralPacked`=0. Release is synchronous to the next edge.
- Latency is 2 cycles:
  - Edge k: the write is sampled and the pixel stored.
  - Edge k+1: the integral is computed from stored data and registered; `BufferReady` updates.
  - Outputs are visible after edge k+1.
- Back-to-back writes (one per cycle) are supported. Each write produces its own result one edge later, pipelined.
- Reset asserted mid-frame aborts the frame; the next write is treated as row 0.

## Structure

- Shared package:
  - `clog2` width helpers (wd, wdI).
  - Packing index function idx(r,c)=(r·n+c)·wdI.
- Sub-module `integral_window_calc`: combinational.
  - Input: n×n window bits.
  - Output: packed integral.
  - Computes a row prefix-sum, then a column prefix-sum.
- The top level holds the line buffer, counters, window extraction (slot rotation maps oldest→r=0) and output registers.

## Test plan

With ImageWidth=7, ImageHeight=5, WindowSize=4; each write is a 1-cycle WE pulse followed by 3 idle cycles:
1. Reset=0, then release → `BufferReady`=0 and `IntegralPacked`=0; no change until the first write.
2. Data=1 for all pixels of rows 0–2 and row 3 columns 0–2 → `BufferReady` stays 0 throughout.
3. Continue: row 3 column 3 write → 2 edges later `BufferReady`=1 and I(r,c)=(r+1)(c+1), so I(3,3)=16 and I(0,0)=1.
4. Row 3 columns 4–6, then row 4 column 0 → ready stays 1 through column 6. After row 4 column 0, `BufferReady`=0 (col<3). Row 4 column 3 → ready=1 and I(3,3)=16.
5. Checkerboard Data=(row+col)&1 → after row 3 column 3: I(3,3)=8, I(0,0)=0, I(1,1)=2.
6. Addr=7 with WE=1 → no state/output change. Reset=0 mid-row → outputs cleared immediately; refilling 4 rows restores correct results.
